// File: rtl/fib_invoker.sv
// -----------------------------------------------------------------------------
// fib_invoker
//   Host-side initiator for one Fibonacci engine instance. A call request
//   (n, a, b) is accepted over a valid/ready handshake. The engine is then
//   launched with a single-cycle r_enable pulse, and the block waits for the
//   engine's w_enable done flag. The result, the WAIT cycle count and a
//   timeout flag are returned over a second valid/ready handshake.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake
//   req_n, req_a, req_b        : call arguments
//   resp_valid/resp_ready      : response handshake
//   resp_data                  : engine result (0 on timeout)
//   resp_timeout               : call aborted after TIMEOUT WAIT cycles
//   resp_cycles                : number of WAIT cycles spent on the call
//   call_count                 : completed responses, wraps modulo 2^16
//   eng_r_enable, eng_control  : engine start pulse / control (tied low)
//   eng_init_n/a/b             : engine init arguments (argument registers)
//   eng_w_enable, eng_result   : engine done flag and result
// -----------------------------------------------------------------------------
module fib_invoker #(
  parameter int N_W     = 6,
  parameter int D_W     = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [N_W-1:0] req_n,
  input  logic [D_W-1:0] req_a,
  input  logic [D_W-1:0] req_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [D_W-1:0] resp_data,
  output logic           resp_timeout,
  output logic [15:0]    resp_cycles,
  output logic [15:0]    call_count,
  output logic           eng_r_enable,
  output logic           eng_control,
  output logic [N_W-1:0] eng_init_n,
  output logic [D_W-1:0] eng_init_a,
  output logic [D_W-1:0] eng_init_b,
  input  logic           eng_w_enable,
  input  logic [D_W-1:0] eng_result
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e          state_q;
  logic            req_ready_q;
  logic            r_enable_q;
  logic            resp_valid_q;
  logic [N_W-1:0]  arg_n_q;
  logic [D_W-1:0]  arg_a_q;
  logic [D_W-1:0]  arg_b_q;
  logic [15:0]     cnt_q;
  logic [D_W-1:0]  resp_data_q;
  logic            resp_timeout_q;
  logic [15:0]     resp_cycles_q;
  logic [15:0]     call_count_q;
  logic [15:0]     cnt_inc_s;

  // Count value this WAIT cycle will reach when it closes.
  assign cnt_inc_s = cnt_q + 16'd1;

  // Call sequencer: request capture, engine launch, done/timeout wait, response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b1;
      r_enable_q     <= 1'b0;
      resp_valid_q   <= 1'b0;
      arg_n_q        <= {N_W{1'b0}};
      arg_a_q        <= {D_W{1'b0}};
      arg_b_q        <= {D_W{1'b0}};
      cnt_q          <= 16'd0;
      resp_data_q    <= {D_W{1'b0}};
      resp_timeout_q <= 1'b0;
      resp_cycles_q  <= 16'd0;
      call_count_q   <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            arg_n_q     <= req_n;
            arg_a_q     <= req_a;
            arg_b_q     <= req_b;
            req_ready_q <= 1'b0;
            r_enable_q  <= 1'b1;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          // The engine restarts on this edge; its done flag is only trusted from WAIT on.
          r_enable_q <= 1'b0;
          cnt_q      <= 16'd0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_inc_s;
          // Done is checked first so a done on the last allowed cycle is not a timeout.
          if (eng_w_enable == 1'b1) begin
            resp_data_q    <= eng_result;
            resp_timeout_q <= 1'b0;
            resp_cycles_q  <= cnt_inc_s;
            resp_valid_q   <= 1'b1;
            state_q        <= ST_RESP;
          end else if (cnt_inc_s == TIMEOUT_C) begin
            resp_data_q    <= {D_W{1'b0}};
            resp_timeout_q <= 1'b1;
            resp_cycles_q  <= TIMEOUT_C;
            resp_valid_q   <= 1'b1;
            state_q        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            call_count_q <= call_count_q + 16'd1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          r_enable_q   <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_timeout = resp_timeout_q;
  assign resp_cycles  = resp_cycles_q;
  assign call_count   = call_count_q;
  assign eng_r_enable = r_enable_q;
  assign eng_control  = 1'b0;
  assign eng_init_n   = arg_n_q;
  assign eng_init_a   = arg_a_q;
  assign eng_init_b   = arg_b_q;

endmodule

// File: tb/tb_fib_invoker.sv
// -----------------------------------------------------------------------------
// tb_fib_invoker
//   Self-checking bench for fib_invoker (TIMEOUT=8). A behavioural engine
//   model raises w_enable in a programmed WAIT cycle; a scoreboard holds the
//   expected response of each call and is checked at every response handshake.
// -----------------------------------------------------------------------------
module tb_fib_invoker;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_n;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_timeout;
  logic [15:0] resp_cycles;
  logic [15:0] call_count;
  logic        eng_r_enable;
  logic        eng_control;
  logic [5:0]  eng_init_n;
  logic [31:0] eng_init_a;
  logic [31:0] eng_init_b;
  logic        eng_w_enable;
  logic [31:0] eng_result;

  typedef struct {
    logic [5:0]  n;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;   // WAIT cycle in which done rises, 0 = never
    logic [31:0] res;
  } cfg_t;

  typedef struct {
    logic [31:0] data;
    logic        tmo;
    logic [15:0] cycles;
  } exp_t;

  cfg_t cfg_q[$];
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int r_pulses = 0;
  int exp_done = 0;
  logic stale = 1'b0;

  // engine model state
  logic        eng_w_q   = 1'b0;
  logic [31:0] eng_res_q = 32'd0;
  int          ecnt      = 0;
  int          cur_lat   = 0;

  // monitor history
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_data  = 32'd0;
  logic [15:0] prev_cyc_f = 16'd0;

  fib_invoker #(.N_W(6), .D_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_timeout(resp_timeout),
    .resp_cycles(resp_cycles), .call_count(call_count),
    .eng_r_enable(eng_r_enable), .eng_control(eng_control),
    .eng_init_n(eng_init_n), .eng_init_a(eng_init_a), .eng_init_b(eng_init_b),
    .eng_w_enable(eng_w_enable), .eng_result(eng_result)
  );

  assign eng_w_enable = eng_w_q | stale;
  assign eng_result   = eng_res_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine model: restarts on r_enable, raises done in the programmed WAIT cycle.
  always @(posedge clk) begin : engine
    cfg_t c;
    if (eng_r_enable) begin
      if (cfg_q.size() > 0) c = cfg_q.pop_front();
      else begin c.lat = 0; c.res = 32'd0; end
      cur_lat   <= c.lat;
      ecnt      <= 1;
      eng_w_q   <= (c.lat == 1);
      eng_res_q <= c.res;
    end else begin
      ecnt <= ecnt + 1;
      if (cur_lat != 0 && ecnt + 1 == cur_lat) eng_w_q <= 1'b1;
    end
  end

  // Monitor: launch pulses, response latency, stability and scoreboard compare.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (eng_r_enable) begin
      r_pulses++;
      start_cyc = cyc;
      if (cfg_q.size() > 0) begin
        check_val("init_n", {26'd0, eng_init_n}, {26'd0, cfg_q[0].n});
        check_val("init_a", eng_init_a, cfg_q[0].a);
        check_val("init_b", eng_init_b, cfg_q[0].b);
      end
    end
    if (resp_valid && !prev_valid) begin
      check_val("resp_unexpected", {31'd0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0)
        check_val("latency", cyc - start_cyc, {16'd0, sb_q[0].cycles} + 32'd1);
    end
    if (prev_valid && !prev_ready) begin
      check_val("valid_held", {31'd0, resp_valid}, 32'd1);
      check_val("data_held", resp_data, prev_data);
      check_val("cycles_held", {16'd0, resp_cycles}, {16'd0, prev_cyc_f});
    end
    if (resp_valid && resp_ready && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("resp_data", resp_data, e.data);
      check_val("resp_timeout", {31'd0, resp_timeout}, {31'd0, e.tmo});
      check_val("resp_cycles", {16'd0, resp_cycles}, {16'd0, e.cycles});
      check_val("count_before", {16'd0, call_count}, exp_done);
      exp_done++;
    end
    prev_valid = resp_valid;
    prev_ready = resp_ready;
    prev_data  = resp_data;
    prev_cyc_f = resp_cycles;
  end

  task automatic push_call(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input logic [31:0] res, input logic to_sb);
    cfg_t c;
    exp_t e;
    c.n = n; c.a = a; c.b = b; c.lat = lat; c.res = res;
    cfg_q.push_back(c);
    if (to_sb) begin
      if (lat == 0 || lat > 8) begin
        e.data = 32'd0; e.tmo = 1'b1; e.cycles = 16'd8;
      end else begin
        e.data = res; e.tmo = 1'b0; e.cycles = 16'(lat);
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic drive_req(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    acc = 1'b0;
    req_n = n; req_a = a; req_b = b; req_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc = 1'b1;
      end
    end
    check_val("req_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(posedge clk);
    #1;
    check_val("sb_drained", sb_q.size(), 32'd0);
  endtask

  initial begin
    int p0;
    rst_n = 1'b0; req_valid = 1'b0; req_n = 6'd0; req_a = 32'd0; req_b = 32'd0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_r_enable", {31'd0, eng_r_enable}, 32'd0);
    check_val("rst_control", {31'd0, eng_control}, 32'd0);
    check_val("rst_init_n", {26'd0, eng_init_n}, 32'd0);
    check_val("rst_init_a", eng_init_a, 32'd0);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_resp_data", resp_data, 32'd0);
    check_val("rst_resp_cycles", {16'd0, resp_cycles}, 32'd0);
    check_val("rst_call_count", {16'd0, call_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Reset during WAIT: the call is dropped and nothing is counted.
    @(posedge clk); #1;
    push_call(6'd3, 32'd5, 32'd6, 0, 32'd0, 1'b0);
    drive_req(6'd3, 32'd5, 32'd6);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_r_enable", {31'd0, eng_r_enable}, 32'd0);
    check_val("mid_rst_init_n", {26'd0, eng_init_n}, 32'd0);
    check_val("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("mid_rst_call_count", {16'd0, call_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_val("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    check_val("post_rst_count", {16'd0, call_count}, 32'd0);
    @(posedge clk); #1;

    // Normal call: done in 5th WAIT cycle.
    p0 = r_pulses;
    push_call(6'd10, 32'd0, 32'd1, 5, 32'h0000_0037, 1'b1);
    drive_req(6'd10, 32'd0, 32'd1);
    wait_drain();
    check_val("single_pulse", r_pulses - p0, 32'd1);
    check_val("count_after_first", {16'd0, call_count}, 32'd1);

    // Timeout, then a fresh normal call.
    push_call(6'd7, 32'd1, 32'd1, 0, 32'hDEAD_BEEF, 1'b1);
    drive_req(6'd7, 32'd1, 32'd1);
    wait_drain();
    push_call(6'd20, 32'd2, 32'd3, 2, 32'h0000_ABCD, 1'b1);
    drive_req(6'd20, 32'd2, 32'd3);
    wait_drain();

    // Done on exactly the last allowed cycle.
    push_call(6'd33, 32'd9, 32'd8, 8, 32'h1234_5678, 1'b1);
    drive_req(6'd33, 32'd9, 32'd8);
    wait_drain();

    // Backpressure: response held, second request waits.
    resp_ready = 1'b0;
    push_call(6'd4, 32'd1, 32'd2, 1, 32'h0000_0011, 1'b1);
    drive_req(6'd4, 32'd1, 32'd2);
    push_call(6'd5, 32'd3, 32'd4, 3, 32'h0000_0022, 1'b1);
    req_n = 6'd5; req_a = 32'd3; req_b = 32'd4; req_valid = 1'b1;
    for (int i = 0; i < 50 && !resp_valid; i++) @(negedge clk);
    p0 = r_pulses;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check_val("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
    end
    check_val("bp_no_pulse", r_pulses - p0, 32'd0);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    drive_req(6'd5, 32'd3, 32'd4);
    wait_drain();

    // Stale done flag during IDLE and START must be ignored.
    stale = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("stale_idle_valid", {31'd0, resp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    push_call(6'd12, 32'd0, 32'd1, 3, 32'h0000_0055, 1'b1);
    drive_req(6'd12, 32'd0, 32'd1);
    @(posedge clk); #1;
    stale = 1'b0;
    wait_drain();

    check_val("final_count", {16'd0, call_count}, 32'd7);
    check_val("final_pulses", r_pulses, 32'd8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
